julia_pixel_scanner: RTL and testbench

JULIA_PIXEL_SCANNER -- requirements
Module: julia_pixel_scanner

---
 rtl/julia_pixel_scanner.sv | 125 ++++++++++++
 tb/tb_julia_pixel_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_scanner.sv
// Walks a Julia-set frame pixel by pixel: hands each pixel's coordinates to the
// iteration engine, waits for its colour, and writes the colour to the frame buffer.
module julia_pixel_scanner #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [31:0]  x_min,
  input  logic signed [31:0]  y_max,
  input  logic signed [31:0]  dx,
  input  logic signed [31:0]  dy,
  output logic                calc_enable,
  output logic signed [31:0]  calc_x0,
  output logic signed [31:0]  calc_y0,
  input  logic                calc_end,
  input  logic [15:0]         calc_color,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [15:0]         wr_data,
  input  logic                wr_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, RUN, WRITE, DONE} state_t;

  state_t             state;
  logic signed [31:0] x_min_q, dx_q, dy_q;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               mask;
  logic               last_col, last_pix;

  assign last_col = (col == COL_W'(H_RES - 1));
  assign last_pix = last_col && (row == ROW_W'(V_RES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_min_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      col         <= '0;
      row         <= '0;
      mask        <= 1'b0;
      calc_enable <= 1'b0;
      calc_x0     <= '0;
      calc_y0     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy       <= 1'b0;
          frame_done <= 1'b0;
          if (start) begin
            x_min_q <= x_min;
            dx_q    <= dx;
            dy_q    <= dy;
            calc_x0 <= x_min;
            calc_y0 <= y_max;
            col     <= '0;
            row     <= '0;
            wr_addr <= '0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          calc_enable <= 1'b1;
          mask        <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          // The engine's done flag may still be high from the previous pixel.
          if (mask) begin
            mask <= 1'b0;
          end else if (calc_end) begin
            wr_data     <= calc_color;
            calc_enable <= 1'b0;
            wr_en       <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_pix) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              wr_addr <= wr_addr + 1'b1;
              if (last_col) begin
                col     <= '0;
                row     <= row + 1'b1;
                calc_x0 <= x_min_q;
                calc_y0 <= calc_y0 - dy_q;
              end else begin
                col     <= col + 1'b1;
                calc_x0 <= calc_x0 + dx_q;
              end
              state <= SETUP;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_pixel_scanner.sv
// Directed bench for julia_pixel_scanner on a 4x3 frame with a 5-cycle engine model.
module tb_julia_pixel_scanner;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [31:0] x_min = '0, y_max = '0, dx = '0, dy = '0;
  logic               calc_enable;
  logic signed [31:0] calc_x0, calc_y0;
  logic               calc_end = 1'b0;
  logic [15:0]        calc_color = '0;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic [15:0]        wr_data;
  logic               wr_ready = 1'b1;
  logic               busy, frame_done;

  julia_pixel_scanner #(.H_RES(4), .V_RES(3), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_min(x_min), .y_max(y_max), .dx(dx), .dy(dy),
    .calc_enable(calc_enable), .calc_x0(calc_x0), .calc_y0(calc_y0),
    .calc_end(calc_end), .calc_color(calc_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Engine model: colour is the per-frame pixel ordinal, done after 5 enabled cycles.
  // In stale mode the done flag is only dropped on the first enabled cycle.
  logic       stale = 1'b0;
  int         cnt = 0;
  logic [15:0] pix = '0;
  always @(posedge clk) begin
    if (rst || frame_done) pix <= '0;
    if (rst) begin
      cnt <= 0; calc_end <= 1'b0;
    end else if (!calc_enable) begin
      cnt <= 0;
      if (!stale) calc_end <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      if (cnt == 0 && stale) calc_end <= 1'b0;
      if (cnt == 4) begin
        calc_end   <= 1'b1;
        calc_color <= pix;
        pix        <= pix + 1'b1;
      end
    end
  end

  // Frame-buffer side: stalls and scoreboard, sampled on the falling edge.
  logic signed [31:0] m_xm, m_ym, m_dx, m_dy;
  int   exp_idx = 0, nwr = 0, nfd = 0, low_cnt = 0, hold6 = 0;
  int   stall_addr = -1, stall_len = 0, stall_cnt = 0;
  logic chk5 = 1'b0, chkwrap = 1'b0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_idx = 0; wr_ready = 1'b1; low_cnt = 0; prev_en = 1'b0;
    end else begin
      if (!calc_enable) low_cnt++;
      else if (!prev_en) begin
        if (busy) chk("en_gap", 32'(low_cnt >= 2), 32'd1);
        low_cnt = 0;
      end
      prev_en = calc_enable;
      if (wr_en && int'(wr_addr) == stall_addr && stall_cnt < stall_len) begin
        wr_ready = 1'b0; stall_cnt++;
      end else wr_ready = 1'b1;
      if (wr_en && wr_addr == 4'd6) begin
        hold6++;
        chk("hold_data", 32'(wr_data), 32'd6);
      end
      if (wr_en && wr_ready) begin
        chk("wr_addr", 32'(wr_addr), 32'(exp_idx));
        chk("wr_data", 32'(wr_data), 32'(exp_idx));
        chk("x0", calc_x0, 32'(m_xm + 32'(exp_idx % 4) * m_dx));
        chk("y0", calc_y0, 32'(m_ym - 32'(exp_idx / 4) * m_dy));
        if (chk5 && wr_addr == 4'd5) begin
          chk("px5_x", calc_x0, 32'hFFFF_F000);
          chk("px5_y", calc_y0, 32'h0000_0800);
        end
        if (chkwrap && wr_addr == 4'd2) chk("x0_wrap", 32'(calc_x0 < 0), 32'd1);
        exp_idx++; nwr++;
      end
      if (frame_done) begin nfd++; exp_idx = 0; end
    end
  end

  task automatic set_par(input logic [31:0] xm, ym, ddx, ddy);
    x_min = xm; y_max = ym; dx = ddx; dy = ddy;
    m_xm = xm; m_ym = ym; m_dx = ddx; m_dy = ddy;
  endtask

  task automatic go(input logic [31:0] xm, ym, ddx, ddy);
    @(negedge clk);
    set_par(xm, ym, ddx, ddy);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fd();
    int n0 = nfd;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (nfd > n0) return;
    end
    chk("timeout_frame_done", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int n0, f0;
  initial begin
    // reset state
    idle(2); #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cen", 32'(calc_enable), 0);
    chk("rst_fd", 32'(frame_done), 0);
    @(negedge clk); rst = 1'b0;
    idle(3);

    // normal frame, stall on address 6, spurious start and parameter change mid-frame
    stall_addr = 6; stall_len = 3; stall_cnt = 0; hold6 = 0; chk5 = 1'b1;
    n0 = nwr; f0 = nfd;
    go(32'hFFFF_E000, 32'h0000_1800, 32'h1000, 32'h1000);
    @(negedge clk); #1;
    chk("busy_run", 32'(busy), 1);
    for (int i = 0; i < 300 && nwr - n0 < 3; i++) @(negedge clk);
    idle(3);
    start = 1'b1; x_min = 32'h1234_5678; dx = 32'h55; dy = 32'h77; y_max = 32'h99;
    @(negedge clk); start = 1'b0;
    wait_fd();
    idle(30);
    chk("f1_writes", 32'(nwr - n0), 32'd12);
    chk("f1_done_pulses", 32'(nfd - f0), 32'd1);
    chk("f1_hold6", 32'(hold6), 32'd4);
    chk("idle_busy", 32'(busy), 0);
    chk5 = 1'b0; stall_addr = -1;

    // reset mid-WRITE at address 7
    stall_addr = 7; stall_len = 1000; stall_cnt = 0;
    go(32'h100, 32'h200, 32'h10, 32'h20);
    for (int i = 0; i < 400 && !(wr_en && wr_addr == 4'd7); i++) @(negedge clk);
    chk("reached_a7", 32'(wr_en && wr_addr == 4'd7), 32'd1);
    rst = 1'b1; #1;
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_addr", 32'(wr_addr), 0);
    chk("arst_data", 32'(wr_data), 0);
    chk("arst_x0", calc_x0, 0);
    chk("arst_y0", calc_y0, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cen", 32'(calc_enable), 0);
    @(negedge clk); rst = 1'b0; stall_addr = -1; stall_len = 0;
    n0 = nwr;
    idle(15);
    chk("no_write_after_rst", 32'(nwr - n0), 0);
    go(32'hFFFF_0000, 32'h0001_0000, 32'h800, 32'h400);
    wait_fd();
    chk("restart_writes", 32'(nwr - n0), 32'd12);

    // stale engine done flag held across pixels
    stale = 1'b1; n0 = nwr;
    go(32'h0, 32'h0, 32'h1, 32'h1);
    wait_fd();
    chk("stale_writes", 32'(nwr - n0), 32'd12);
    stale = 1'b0;
    idle(3);

    // coordinate wrap
    chkwrap = 1'b1; n0 = nwr;
    go(32'h0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_fd();
    chk("wrap_writes", 32'(nwr - n0), 32'd12);
    chkwrap = 1'b0;

    // start held high: next frame begins right after IDLE is reached
    @(negedge clk);
    set_par(32'h40, 32'h80, 32'h3, 32'h5);
    start = 1'b1; n0 = nwr;
    wait_fd();
    @(negedge clk); #1;
    chk("held_idle_busy", 32'(busy), 0);
    @(negedge clk); #1;
    chk("held_restart_busy", 32'(busy), 1);
    start = 1'b0;
    wait_fd();
    chk("held_writes", 32'(nwr - n0), 32'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
